// File: rtl/rtc_cfg_sequencer.sv
// rtc_cfg_sequencer: APB master that programs the RTC block (disable, INIT_*, CONFIG, enable) from one start pulse.
// Optional feature macro RTC_SEQ_READBACK_EN: reads INIT_* back after CONFIG and checks them before enabling.
module rtc_cfg_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        start_i,
  input  logic [31:0] cfg_i,
  input  logic [5:0]  init_sec_i,
  input  logic [5:0]  init_min_i,
  input  logic [6:0]  init_hours_i,
  input  logic [2:0]  init_dow_i,
  input  logic [4:0]  init_dom_i,
  input  logic [3:0]  init_month_i,
  input  logic [11:0] init_year_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  localparam int unsigned IDX_W = 5;
`ifdef RTC_SEQ_READBACK_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(16);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(9);
`endif
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, NEXT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d, snap_en, rd_bad, rd_next;

  logic [5:0]  sec_q, min_q;
  logic [6:0]  hours_q;
  logic [2:0]  dow_q;
  logic [4:0]  dom_q;
  logic [3:0]  month_q;
  logic [11:0] year_q;
  logic [31:0] cfg_q;

  // Snapshot field k (0=sec .. 6=year), zero-extended
  function automatic logic [31:0] field(input logic [2:0] k);
    case (k)
      3'd0:    return 32'(sec_q);
      3'd1:    return 32'(min_q);
      3'd2:    return 32'(hours_q);
      3'd3:    return 32'(dow_q);
      3'd4:    return 32'(dom_q);
      3'd5:    return 32'(month_q);
      3'd6:    return 32'(year_q);
      default: return 32'h0;
    endcase
  endfunction

  // Step index -> register offset: 0 disable, 1..7 INIT_*, 8 CONFIG, reads, LAST enable
  function automatic logic [31:0] offset_of(input logic [IDX_W-1:0] i);
    if (i >= IDX_W'(1) && i <= IDX_W'(7)) return 32'h28 + (32'(i - IDX_W'(1)) << 2);
    if (i == IDX_W'(8))                   return 32'h04;
`ifdef RTC_SEQ_READBACK_EN
    if (i >= IDX_W'(9) && i <= IDX_W'(15)) return 32'h28 + (32'(i - IDX_W'(9)) << 2);
`endif
    return 32'h0;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [IDX_W-1:0] i);
    if (i >= IDX_W'(1) && i <= IDX_W'(7)) return field(3'(i - IDX_W'(1)));
    if (i == IDX_W'(8))                   return cfg_q;
    if (i == LAST_IDX)                    return 32'h1;
    return 32'h0;
  endfunction

`ifdef RTC_SEQ_READBACK_EN
  function automatic logic is_read(input logic [IDX_W-1:0] i);
    return (i >= IDX_W'(9)) && (i <= IDX_W'(15));
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] k);
    case (k)
      3'd0, 3'd1: return 32'h3F;
      3'd2:       return 32'h7F;
      3'd3:       return 32'h7;
      3'd4:       return 32'h1F;
      3'd5:       return 32'hF;
      default:    return 32'hFFF;
    endcase
  endfunction

  logic [2:0] rd_k;
  assign rd_k    = 3'(idx_q - IDX_W'(9));
  assign rd_bad  = is_read(idx_q) && ((prdata_i & field_mask(rd_k)) != field(rd_k));
  assign rd_next = is_read(idx_d);
`else
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
  assign rd_bad  = 1'b0;
  assign rd_next = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Aborts jump the index to the last step so NEXT heads straight to DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_o;
    snap_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          idx_d   = '0;
          err_d   = 1'b0;
          snap_en = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (pready_i) begin
          state_d = NEXT;
          if (pslverr_i || rd_bad) begin
            err_d = 1'b1;
            idx_d = LAST_IDX;
          end
        end else if (cnt_q >= CNT_LAST) begin
          state_d = NEXT;
          err_d   = 1'b1;
          idx_d   = LAST_IDX;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sec_q   <= '0;
      min_q   <= '0;
      hours_q <= '0;
      dow_q   <= '0;
      dom_q   <= '0;
      month_q <= '0;
      year_q  <= '0;
      cfg_q   <= '0;
    end else if (snap_en) begin
      sec_q   <= init_sec_i;
      min_q   <= init_min_i;
      hours_q <= init_hours_i;
      dow_q   <= init_dow_i;
      dom_q   <= init_dom_i;
      month_q <= init_month_i;
      year_q  <= init_year_i;
      cfg_q   <= cfg_i;
    end
  end

  // Outputs registered from the next state; address/data loaded on entry to SETUP and held
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      busy_o    <= (state_d == SETUP) || (state_d == ACCESS) || (state_d == NEXT);
      done_o    <= (state_d == DONE);
      err_o     <= err_d;
      psel_o    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_o <= (state_d == ACCESS);
      if (state_d == SETUP) begin
        paddr_o  <= BASE_ADDR + offset_of(idx_d);
        pwdata_o <= wdata_of(idx_d);
        pwrite_o <= !rd_next;
      end
    end
  end

endmodule
